// File: rtl/mapped_bus_pkg.sv
// Shared types and helpers for the memory-mapped bus controller and its region decoder.
package mapped_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int WAIT_W = 3;

  // Low bit of slice idx in a packed per-region vector of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/addr_region_decode.sv
// Base/mask region match with lowest-index priority; purely combinational.
module addr_region_decode #(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_W      = 16,
  parameter int IDX_W       = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hFE00, 16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFE00, 16'hFF00, 16'hFE00}
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mapped_bus_ctrl.sv
// CPU-side bus controller: decodes accesses onto one-hot slave selects with per-region
// wait states, registers read data and keeps a sticky unmapped-access error.
module mapped_bus_ctrl
  import mapped_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hFE00, 16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFE00, 16'hFF00, 16'hFE00},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {3'd1, 3'd1, 3'd1}
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          req,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             din,
  input  logic                          read_en,
  output logic [DATA_W-1:0]             dout,
  output logic                          ready,
  input  logic                          err_clr,
  output logic                          err,
  output logic [ADDR_W-1:0]             err_addr,
  output logic [NUM_REGIONS-1:0]        dev_cs,
  output logic                          dev_we,
  output logic [ADDR_W-1:0]             dev_addr,
  output logic [DATA_W-1:0]             dev_din,
  input  logic [NUM_REGIONS*DATA_W-1:0] dev_dout
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]    region_q, region_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                rd_q, rd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [DATA_W-1:0]   slave_rdata;

  addr_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr_i (addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign slave_rdata = dev_dout[slice_lo(int'(region_q), DATA_W) +: DATA_W];

  // NOTE: every next-state variable takes its held value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    region_d   = region_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    // Clear first so a miss in the same cycle overrides it.
    if (err_clr) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = addr;
          din_d  = din;
          rd_d   = read_en;
          if (dec_hit) begin
            region_d = dec_idx;
            cnt_d    = REGION_WAIT[slice_lo(int'(dec_idx), WAIT_W) +: WAIT_W];
            state_d  = ACCESS;
          end else begin
            err_d      = 1'b1;
            err_addr_d = addr;
            state_d    = RESP;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (rd_q) rdata_d = slave_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block; all state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      region_q   <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      rd_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      region_q   <= region_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Selects decode from registered state only, so reset drops them on the next cycle.
  always_comb begin
    dev_cs = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      dev_cs[i] = (state_q == ACCESS) && (region_q == IDX_W'(i));
    end
  end

  assign dev_we   = (state_q == ACCESS) && (cnt_q == '0) && !rd_q;
  assign ready    = (state_q == RESP);
  assign dout     = rdata_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign dev_addr = addr_q;
  assign dev_din  = din_q;

endmodule
